// File: rtl/bin2bcd_serial_if.sv
// Handshake bundle between a binary producer, the serial BCD converter and the
// display-side consumer. The converter takes the slave view.
interface bin2bcd_serial_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ack;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;

  modport slave (
    input  in_valid, bin_in, out_ack,
    output in_ready, out_valid, bcd_out, busy
  );

  modport master (
    output in_valid, bin_in, out_ack,
    input  in_ready, out_valid, bcd_out, busy
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one input bit per clock,
// result held in a register until the consumer acknowledges it.
module bin2bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  bin2bcd_serial_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

  if (pow10(DIGITS) <= MAX_IN) begin : g_bad_params
    $error("bin2bcd_serial: DIGITS too small to hold 2^WIDTH-1");
  end

  // Add 3 to every digit that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[4*d +: 4] >= 4'd5) r[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [WIDTH-1:0]        sh_p0;
  logic [ACC_W-1:0]        acc_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic [ACC_W-1:0]        bcd_p1;

  logic [ACC_W-1:0]        adj;
  logic [ACC_W+WIDTH-1:0]  cat_nx;
  logic                    last_shift;

  assign adj        = add3(acc_p0);
  assign cat_nx     = {adj, sh_p0} << 1;
  assign last_shift = (state == SHIFT) && (cnt_p0 == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nx = SHIFT;
        SHIFT:   if (last_shift)   state_nx = DONE;
        DONE:    if (bus.out_ack)  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // p0: shift/accumulate datapath; p1: result register seen by the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p0  <= '0;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      bcd_p1 <= '0;
    end else if (clear) begin
      sh_p0  <= '0;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      bcd_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_p0  <= bus.bin_in;
            acc_p0 <= '0;
            cnt_p0 <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          acc_p0 <= cat_nx[ACC_W+WIDTH-1:WIDTH];
          sh_p0  <= cat_nx[WIDTH-1:0];
          cnt_p0 <= cnt_p0 - CNT_W'(1);
          if (last_shift) bcd_p1 <= cat_nx[ACC_W+WIDTH-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_valid = (state == DONE);
  assign bus.bcd_out   = bcd_p1;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: handshake timing, boundary values,
// abort paths and a full 0..255 sweep against a divide/modulo reference.
module tb_bin2bcd_serial;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  logic seen_valid;

  bin2bcd_serial_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    check("wait_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp,
                         input bit full);
    wait_ready();
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.bin_in   = 8'($urandom);
    if (full) begin
      check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end
    repeat (7) tick();
    if (full) check({tag, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp));
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    if (full) begin
      check({tag, "_ack_valid_low"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_ack_ready"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  logic [7:0]  bv [7];
  logic [11:0] be [7];

  initial begin
    bv = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200};
    be = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199, 12'h200};
    bus.in_valid = 1'b0;
    bus.bin_in   = 8'd0;
    bus.out_ack  = 1'b0;

    // Reset state
    #2;
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    convert("c255", 8'd255, 12'h255, 1'b1);

    for (int i = 0; i < 7; i++) convert("bound", bv[i], be[i], 1'b1);

    // in_valid held high with bin_in wandering during SHIFT and DONE
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd42;
    tick();
    check("hold_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      bus.bin_in = 8'($urandom);
      tick();
    end
    check("hold_in_ready_shift", 32'(bus.in_ready), 32'd0);
    check("hold_no_early_valid", 32'(bus.out_valid), 32'd0);
    bus.bin_in = 8'd77;
    tick();
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    check("hold_bcd42", 32'(bus.bcd_out), 32'h042);
    check("hold_in_ready_done", 32'(bus.in_ready), 32'd0);
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    check("hold_ack_ready", 32'(bus.in_ready), 32'd1);
    check("hold_ack_valid", 32'(bus.out_valid), 32'd0);
    check("hold_bcd_kept", 32'(bus.bcd_out), 32'h042);
    tick();
    check("spacing10_busy", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    repeat (8) tick();
    check("second_valid", 32'(bus.out_valid), 32'd1);
    check("second_bcd77", 32'(bus.bcd_out), 32'h077);
    tick();
    check("done_stable_valid", 32'(bus.out_valid), 32'd1);
    check("done_stable_bcd", 32'(bus.bcd_out), 32'h077);
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;

    // out_ack held across a whole conversion
    bus.out_ack  = 1'b1;
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd123;
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    check("ackhold_no_early", 32'(bus.out_valid), 32'd0);
    tick();
    check("ackhold_valid", 32'(bus.out_valid), 32'd1);
    check("ackhold_bcd", 32'(bus.bcd_out), 32'h123);
    tick();
    check("ackhold_gone", 32'(bus.out_valid), 32'd0);
    check("ackhold_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ack = 1'b0;

    // clear four edges into SHIFT
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd200;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    check("clr_bcd", 32'(bus.bcd_out), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_valid = seen_valid | bus.out_valid;
    end
    check("clr_never_valid", 32'(seen_valid), 32'd0);

    // clear together with out_ack in DONE
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd56;
    tick();
    bus.in_valid = 1'b0;
    repeat (8) tick();
    check("clrack_valid", 32'(bus.out_valid), 32'd1);
    check("clrack_bcd56", 32'(bus.bcd_out), 32'h056);
    clear       = 1'b1;
    bus.out_ack = 1'b1;
    tick();
    clear       = 1'b0;
    bus.out_ack = 1'b0;
    check("clrack_valid_low", 32'(bus.out_valid), 32'd0);
    check("clrack_bcd0", 32'(bus.bcd_out), 32'd0);
    check("clrack_ready", 32'(bus.in_ready), 32'd1);

    // asynchronous reset between edges mid-SHIFT
    convert("pre_rst", 8'd231, 12'h231, 1'b0);
    bus.in_valid = 1'b1;
    bus.bin_in   = 8'd99;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_bcd", 32'(bus.bcd_out), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    #1 rst_n = 1'b1;
    tick();
    convert("post_rst128", 8'd128, 12'h128, 1'b1);

    for (int v = 0; v < 256; v++) convert("sweep", 8'(v), ref_bcd(v), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
